// File: rtl/demux_1x4_buf.sv
// Buffered 1-to-4 demultiplexer. One producer feeds a small in-order FIFO of
// {sel, data} entries. The head entry is offered to the consumer selected by
// its sel field through a one-hot out_valid and a shared out_data bus.
// Optional feature macro: DEMUX_XFER_CNT_EN adds the xfer_cnt port, which
// holds saturating per-consumer transfer counters.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | count == 0, nothing offered, out_ready ignored
// ST_PART  | 0 < count < DEPTH, can accept and offer
// ST_FULL  | count == DEPTH, input refused (no pass-through)
module demux_1x4_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [63:0]      xfer_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PART  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [WIDTH+1:0] mem [DEPTH];

    logic [1:0]       head_sel;
    logic [WIDTH-1:0] head_data;
    logic             push, pop;

    assign head_sel  = mem[rd_ptr][WIDTH+1:WIDTH];
    assign head_data = mem[rd_ptr][WIDTH-1:0];

    // Handshake and output decode; everything is gated off while rst is high
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 4'b0000;
        out_data  = '0;
        if (!rst) begin
            in_ready = (state != ST_FULL);
            if (state != ST_EMPTY) begin
                out_valid = 4'b0001 << head_sel;
                out_data  = head_data;
            end
        end
        push = in_valid & in_ready;
        pop  = |(out_valid & out_ready);
    end

    // Occupancy bookkeeping and next-state decode
    always_comb begin
        count_next = count;
        state_next = state;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        case (state)
            ST_EMPTY: if (push) state_next = ST_PART;
            ST_PART: begin
                if (push && !pop && count_next == CW'(DEPTH))
                    state_next = ST_FULL;
                else if (pop && !push && count == CW'(1))
                    state_next = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_next = ST_PART;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // State, occupancy and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_sel, in_data};
    end

`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] xfer_q [4];

    for (genvar k = 0; k < 4; k++) begin : g_xfer
        // Saturating count of completed transfers on lane k
        always_ff @(posedge clk) begin
            if (rst)
                xfer_q[k] <= '0;
            else if (out_valid[k] && out_ready[k] && xfer_q[k] != 16'hFFFF)
                xfer_q[k] <= xfer_q[k] + 16'd1;
        end
        assign xfer_cnt[16*k +: 16] = xfer_q[k];
    end
`endif

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Bench for demux_1x4_buf: a queue-based reference model predicts in_ready,
// out_valid, out_data (and xfer_cnt when DEMUX_XFER_CNT_EN is defined) every cycle.
module tb_demux_1x4_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       in_sel = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = '0;
`ifdef DEMUX_XFER_CNT_EN
    logic [63:0]      xfer_cnt;
`endif

    demux_1x4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] delivered[$];
    int          xfer_exp[4];
    int          tests_run = 0;
    int          tests_failed = 0;

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [3:0] r, input string tag, output logic acc);
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
        logic        popped;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_ready = (q.size() != DEPTH);
        exp_valid = (q.size() != 0) ? (4'b0001 << q[0].sel) : 4'b0000;
        exp_data  = (q.size() != 0) ? q[0].data : 32'h0;
        tests_run++;
        if (in_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL %s in_ready got %b expected %b", tag, in_ready, exp_ready);
        end
        tests_run++;
        if (out_valid !== exp_valid) begin
            tests_failed++;
            $display("FAIL %s out_valid got %b expected %b", tag, out_valid, exp_valid);
        end
        tests_run++;
        if (out_data !== exp_data) begin
            tests_failed++;
            $display("FAIL %s out_data got %h expected %h", tag, out_data, exp_data);
        end
`ifdef DEMUX_XFER_CNT_EN
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (xfer_cnt[16*k +: 16] !== 16'(xfer_exp[k])) begin
                tests_failed++;
                $display("FAIL %s xfer_cnt[%0d] got %h expected %h", tag, k,
                         xfer_cnt[16*k +: 16], 16'(xfer_exp[k]));
            end
        end
`endif
        acc    = v && exp_ready;
        popped = (q.size() != 0) && r[q[0].sel];
        if (popped) begin
            delivered.push_back(q[0].data);
            if (xfer_exp[q[0].sel] < 65535) xfer_exp[q[0].sel]++;
            void'(q.pop_front());
        end
        if (acc) q.push_back('{sel: s, data: d});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic v, input logic [3:0] r);
        rst       = 1'b1;
        in_valid  = v;
        in_sel    = 2'($urandom_range(3));
        in_data   = $urandom;
        out_ready = r;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_in_ready got %b expected 0", in_ready);
        end
        tests_run++;
        if (out_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rst_out_valid got %b expected 0000", out_valid);
        end
        tests_run++;
        if (out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_out_data got %h expected 0", out_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        delivered.delete();
        for (int k = 0; k < 4; k++) xfer_exp[k] = 0;
    endtask

    task automatic test_reset();
        logic acc;
        do_reset(1'b0, 4'b0000);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "reset_idle", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b0000, "reset_idle2", acc);
    endtask

    task automatic test_single_route();
        logic acc;
        cycle(1'b1, 2'd2, 32'hDEADBEEF, 4'b1111, "single_push", acc);
        tests_run++;
        if (acc !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_accept got %b expected 1", acc);
        end
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "single_deliver", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "single_after", acc);
    endtask

    task automatic test_fill_backpressure();
        logic acc;
        int   guard;
        delivered.delete();
        cycle(1'b1, 2'd0, 32'hAAAA0000, 4'b0000, "fill_A", acc);
        cycle(1'b1, 2'd3, 32'hBBBB3333, 4'b0000, "fill_B", acc);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'd2, 32'hCCCC2222, 4'b0000, "fill_C_held", acc);
            tests_run++;
            if (acc !== 1'b0) begin
                tests_failed++;
                $display("FAIL fill_C_refused got %b expected 0", acc);
            end
        end
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 10) begin
            cycle(1'b1, 2'd2, 32'hCCCC2222, 4'b0001, "fill_drain_A", acc);
            guard++;
        end
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 2'd0, 32'h0, 4'b0001, "fill_B_stall", acc);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 2'd0, 32'h0, 4'b1111, "fill_drain", acc);
        tests_run++;
        if (delivered.size() != 3 || delivered[0] !== 32'hAAAA0000 ||
            delivered[1] !== 32'hBBBB3333 || delivered[2] !== 32'hCCCC2222) begin
            tests_failed++;
            $display("FAIL fill_order got %0d words expected A,B,C", delivered.size());
        end
    endtask

    task automatic test_hol_blocking();
        logic acc;
        cycle(1'b1, 2'd1, 32'h11111111, 4'b0000, "hol_push1", acc);
        cycle(1'b1, 2'd0, 32'h00000000, 4'b1101, "hol_push0", acc);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 2'd0, 32'h0, 4'b1101, "hol_blocked", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b0010, "hol_release", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "hol_second", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "hol_empty", acc);
    endtask

    task automatic test_streaming();
        logic acc;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 2'(i % 4), $urandom, 4'b1111, "stream", acc);
            tests_run++;
            if (acc !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_accept cycle %0d got %b expected 1", i, acc);
            end
        end
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "stream_tail", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "stream_done", acc);
    endtask

    task automatic test_random();
        logic        acc;
        logic        v = 1'b0;
        logic [1:0]  s = '0;
        logic [31:0] d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!v || acc) begin
                v = ($urandom_range(3) != 0);
                s = 2'($urandom_range(3));
                d = $urandom;
            end
            cycle(v, s, d, 4'($urandom), "random", acc);
            if (!v) acc = 1'b1;
        end
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 2'd0, 32'h0, 4'b1111, "random_drain", acc);
    endtask

    task automatic test_reset_mid();
        logic acc;
        cycle(1'b1, 2'd1, 32'h5A5A0001, 4'b1111, "mid_xfer", acc);
        cycle(1'b1, 2'd2, 32'h5A5A0002, 4'b0000, "mid_fill1", acc);
        cycle(1'b1, 2'd3, 32'h5A5A0003, 4'b0000, "mid_fill2", acc);
        cycle(1'b1, 2'd0, 32'h5A5A0004, 4'b0000, "mid_full", acc);
        do_reset(1'b1, 4'b1111);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 2'd0, 32'h0, 4'b1111, "mid_after_rst", acc);
`ifdef DEMUX_XFER_CNT_EN
        for (int i = 0; i < 65535; i++)
            cycle(1'b1, 2'd0, i, 4'b1111, "sat_preload", acc);
        cycle(1'b1, 2'd0, 32'hFFFF0000, 4'b1111, "sat_extra", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "sat_last", acc);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, "sat_hold", acc);
        tests_run++;
        if (xfer_cnt[15:0] !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_lane0 got %h expected ffff", xfer_cnt[15:0]);
        end
`endif
    endtask

    initial begin
        for (int k = 0; k < 4; k++) xfer_exp[k] = 0;
        @(negedge clk);
        test_reset();
        test_single_route();
        test_fill_backpressure();
        test_hol_blocking();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
